// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage (master) and a data-memory
// responder (slave) using the Stall/Done handshake.
interface dmem_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic        createdump;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr, createdump,
        input  DataOut, Done, Stall, CacheHit, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr, createdump,
        output DataOut, Done, Stall, CacheHit, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word-addressed data memory answering the Stall/Done protocol:
// one request in flight, Done pulses LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state_reg;
    logic [3:0]            cnt_reg;
    logic [DEPTH_LOG2-1:0] idx_reg;
    logic [15:0]           wdata_reg;
    logic                  rd_reg;
    logic                  wr_reg;
    logic                  err_reg;
    logic [15:0]           rdata_reg;
    logic [15:0]           mem [0:(1<<DEPTH_LOG2)-1];

    logic                  accept;
    logic                  req_err;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  unused_bits;

    assign accept  = (state_reg == IDLE) && (bus.Rd || bus.Wr);
    assign req_err = (bus.Rd && bus.Wr) || bus.Addr[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= '0;
            wdata_reg <= 16'h0000;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        idx_reg   <= bus.Addr[DEPTH_LOG2:1];
                        wdata_reg <= bus.DataIn;
                        rd_reg    <= bus.Rd;
                        wr_reg    <= bus.Wr;
                        err_reg   <= req_err;
                        cnt_reg   <= 4'(LATENCY - 1);
                        if (LATENCY == 1)
                            state_reg <= DONE;
                        else
                            state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1)
                        state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The read port follows the live address while idle so a LATENCY=1 read
    // still has its data registered on the edge that enters DONE.
    assign rd_idx = (state_reg == IDLE) ? bus.Addr[DEPTH_LOG2:1] : idx_reg;
    assign mem_we = (state_reg == DONE) && wr_reg && !err_reg;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx_reg] <= wdata_reg;
        rdata_reg <= mem[rd_idx];
    end

    assign bus.Done     = (state_reg == DONE);
    assign bus.Stall    = (state_reg == BUSY) || accept;
    assign bus.DataOut  = ((state_reg == DONE) && rd_reg && !err_reg) ? rdata_reg : 16'h0000;
    assign bus.err      = (state_reg == DONE) && err_reg;
    assign bus.CacheHit = 1'b0;

    // createdump and the wrapped upper address bits are deliberately ignored.
    assign unused_bits = ^{bus.createdump, bus.Addr[15:DEPTH_LOG2+1]};
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed checks of dmem_responder against a word-array model,
// for a LATENCY=4 instance and a LATENCY=1 instance.
module tb_dmem_responder;
    localparam int LAT = 4;
    localparam int DL  = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] ref_mem [1024];
    bit          ref_ok  [1024];
    logic [9:0]  pool    [8];

    dmem_if bus4();
    dmem_if bus1();

    dmem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    dmem_responder #(.LATENCY(1),   .DEPTH_LOG2(DL)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advances cycle by cycle until Done (bounded); reports cycles taken and
    // whether Stall stayed high on every cycle before Done.
    task automatic wait_done(output int cycles, output bit stall_ok, input bit drop);
        cycles   = 0;
        stall_ok = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (drop) begin
                bus4.Rd     = 1'b0;
                bus4.Wr     = 1'b0;
                bus4.Addr   = 16'($urandom);
                bus4.DataIn = 16'($urandom);
            end
            #1;
            if (!bus4.Done && !bus4.Stall)
                stall_ok = 1'b0;
        end while (!bus4.Done && cycles < 64);
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input bit hold, output logic [15:0] got);
        int          cyc;
        bit          st;
        bit          e;
        bit          known;
        logic [9:0]  idx;
        logic [15:0] exp;
        int          reps;
        e     = (rd && wr) || addr[0];
        idx   = addr[DL:1];
        known = ref_ok[idx];
        exp   = (rd && !e) ? ref_mem[idx] : 16'h0000;
        @(negedge clk);
        bus4.Rd = rd; bus4.Wr = wr; bus4.Addr = addr; bus4.DataIn = data;
        #1;
        check("stall_on_accept", {31'd0, bus4.Stall}, 32'd1);
        reps = hold ? 2 : 1;
        for (int r = 0; r < reps; r++) begin
            wait_done(cyc, st, !hold || r == 1);
            check("latency", cyc, LAT);
            check("stall_in_flight", {31'd0, st}, 32'd1);
            check("stall_at_done", {31'd0, bus4.Stall}, 32'd0);
            check("err", {31'd0, bus4.err}, {31'd0, e});
            if (!rd || e || known)
                check("dataout", {16'd0, bus4.DataOut}, {16'd0, exp});
            got = bus4.DataOut;
            if (hold && r == 0) begin
                @(negedge clk);
                #1;
                check("no_double_done", {31'd0, bus4.Done}, 32'd0);
                check("reaccept_stall", {31'd0, bus4.Stall}, 32'd1);
            end
        end
        if (wr && !e) begin
            ref_mem[idx] = data;
            ref_ok[idx]  = 1'b1;
        end
    endtask

    task automatic txn1(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input logic [15:0] exp_data, input bit exp_err);
        @(negedge clk);
        bus1.Rd = rd; bus1.Wr = wr; bus1.Addr = addr; bus1.DataIn = data;
        #1;
        check("l1_stall_c0", {31'd0, bus1.Stall}, 32'd1);
        check("l1_nodone_c0", {31'd0, bus1.Done}, 32'd0);
        @(negedge clk);
        bus1.Rd = 1'b0; bus1.Wr = 1'b0;
        #1;
        check("l1_done_c1", {31'd0, bus1.Done}, 32'd1);
        check("l1_stall_c1", {31'd0, bus1.Stall}, 32'd0);
        check("l1_data", {16'd0, bus1.DataOut}, {16'd0, exp_data});
        check("l1_err", {31'd0, bus1.err}, {31'd0, exp_err});
        @(negedge clk);
        #1;
        check("l1_idle_c2", {30'd0, bus1.Done, bus1.Stall}, 32'd0);
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] addr;
        bit          done_seen;
        int          k;
        int          kind;

        bus4.Rd = 0; bus4.Wr = 0; bus4.Addr = 0; bus4.DataIn = 0; bus4.createdump = 0;
        bus1.Rd = 0; bus1.Wr = 0; bus1.Addr = 0; bus1.DataIn = 0; bus1.createdump = 0;
        for (int i = 0; i < 1024; i++) ref_ok[i] = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outs4", {bus4.DataOut, 12'd0, bus4.Done, bus4.Stall, bus4.err, bus4.CacheHit}, 32'd0);
        check("reset_outs1", {bus1.DataOut, 12'd0, bus1.Done, bus1.Stall, bus1.err, bus1.CacheHit}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        txn(0, 1, 16'h0010, 16'hBEEF, 0, got);
        txn(1, 0, 16'h0010, 16'h0000, 0, got);
        check("beef_readback", {16'd0, got}, 32'h0000_BEEF);
        txn(1, 0, 16'h0010, 16'h0000, 1, got);
        txn(1, 0, 16'h0011, 16'h0000, 0, got);
        txn(0, 1, 16'h0020, 16'h1111, 0, got);
        txn(1, 1, 16'h0020, 16'h9999, 0, got);
        txn(1, 0, 16'h0020, 16'h0000, 0, got);
        check("rdwr_err_nowrite", {16'd0, got}, 32'h0000_1111);
        txn(0, 1, 16'h0802, 16'h1234, 0, got);
        txn(1, 0, 16'h0002, 16'h0000, 0, got);
        check("addr_wrap", {16'd0, got}, 32'h0000_1234);

        // Reset during an in-flight write must discard it
        txn(0, 1, 16'h0040, 16'h5555, 0, got);
        @(negedge clk);
        bus4.Wr = 1; bus4.Addr = 16'h0040; bus4.DataIn = 16'hAAAA;
        @(negedge clk);
        bus4.Wr = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midreset_outs", {bus4.DataOut, 13'd0, bus4.Done, bus4.Stall, bus4.err}, 32'd0);
        done_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (bus4.Done) done_seen = 1'b1;
        end
        check("midreset_no_done", {31'd0, done_seen}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        txn(1, 0, 16'h0040, 16'h0000, 0, got);
        check("midreset_old_data", {16'd0, got}, 32'h0000_5555);

        // Randomized traffic over a small pool of word indices
        for (int i = 0; i < 8; i++) begin
            pool[i] = 10'($urandom);
            txn(0, 1, {5'd0, pool[i], 1'b0}, 16'($urandom), 0, got);
        end
        for (int i = 0; i < 60; i++) begin
            k    = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            addr = (16'($urandom_range(0, 31)) << 11) | {5'd0, pool[k], 1'b0};
            if (kind <= 3)
                txn(0, 1, addr, 16'($urandom), 0, got);
            else if (kind <= 7)
                txn(1, 0, addr, 16'($urandom), ($urandom_range(0, 5) == 0), got);
            else if (kind == 8)
                txn(1, 1, addr, 16'($urandom), 0, got);
            else
                txn(1, 0, addr | 16'h0001, 16'h0000, 0, got);
        end

        // LATENCY=1 instance
        txn1(0, 1, 16'h0006, 16'hCAFE, 16'h0000, 0);
        txn1(1, 0, 16'h0006, 16'h0000, 16'hCAFE, 0);
        txn1(1, 0, 16'h0007, 16'h0000, 16'h0000, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
